pi_seq: RTL and testbench



---
 rtl/pi_seq_pkg.sv | 51 +++++
 rtl/pi_seq_alu.sv | 73 +++++++
 rtl/pi_seq.sv | 172 +++++++++++++++++
 tb/tb_pi_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pi_seq_pkg.sv
// Shared types and constants for the PI sequencer: FSM states, ALU operand
// selects, the sensor channel order and the saturation limits.
package pi_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, CONV, WAIT, ACC, INTG, ICMP, PCMP, RSUB, RHT, LADD, LFT
    } state_t;

    localparam logic [2:0] SRC1_ACCUM  = 3'd0;
    localparam logic [2:0] SRC1_ITERM  = 3'd1;
    localparam logic [2:0] SRC1_ERROR1 = 3'd2;
    localparam logic [2:0] SRC1_ERROR2 = 3'd3;
    localparam logic [2:0] SRC1_FWD    = 3'd4;

    localparam logic [2:0] SRC0_A2D    = 3'd0;
    localparam logic [2:0] SRC0_INTGRL = 3'd1;
    localparam logic [2:0] SRC0_ICOMP  = 3'd2;
    localparam logic [2:0] SRC0_PCOMP  = 3'd3;
    localparam logic [2:0] SRC0_PTERM  = 3'd4;

    localparam logic [15:0] SUM_POS_SAT = 16'h07FF;
    localparam logic [15:0] SUM_NEG_SAT = 16'hF800;
    localparam logic [15:0] MUL_POS_SAT = 16'h3FFF;
    localparam logic [15:0] MUL_NEG_SAT = 16'hC000;

    localparam logic [2:0] LAST_IDX = 3'd5;

    typedef struct packed {
        logic [2:0] src1sel;
        logic [2:0] src0sel;
        logic       multiply;
        logic       sub;
        logic       mult2;
        logic       mult4;
        logic       saturate;
    } alu_ctrl_t;

    // Sensor read order, right to left across the array.
    function automatic logic [2:0] chnnl_of(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'd1;
            3'd1:    return 3'd0;
            3'd2:    return 3'd4;
            3'd3:    return 3'd2;
            3'd4:    return 3'd3;
            3'd5:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/pi_seq_alu.sv
// Shared combinational datapath: operand muxes, scaled add/sub with 12-bit
// saturation, and a signed 15x15 multiply with 15-bit saturation.
module alu
    import pi_seq_pkg::*;
(
    input  logic [15:0] accum,
    input  logic [15:0] pcomp,
    input  logic [11:0] err,
    input  logic [11:0] intgrl,
    input  logic [11:0] icomp,
    input  logic [11:0] a2d_res,
    input  logic [11:0] Iterm,
    input  logic [11:0] Fwd,
    input  logic [13:0] Pterm,
    input  alu_ctrl_t   ctrl,
    output logic [15:0] dst
);

    logic [15:0] src1, src0, scaled, pre_src0, sum, sat_sum, mult_sat;
    logic [29:0] op1, op0, product;
    logic        unused_prod_lsb;

    always_comb begin
        case (ctrl.src1sel)
            SRC1_ACCUM:  src1 = accum;
            SRC1_ITERM:  src1 = {4'h0, Iterm};
            SRC1_ERROR1: src1 = {{4{err[11]}}, err};
            SRC1_ERROR2: src1 = {{8{err[11]}}, err[11:4]};
            SRC1_FWD:    src1 = {4'h0, Fwd};
            default:     src1 = 16'h0000;
        endcase
        case (ctrl.src0sel)
            SRC0_A2D:    src0 = {4'h0, a2d_res};
            SRC0_INTGRL: src0 = {{4{intgrl[11]}}, intgrl};
            SRC0_ICOMP:  src0 = {{4{icomp[11]}}, icomp};
            SRC0_PCOMP:  src0 = pcomp;
            SRC0_PTERM:  src0 = {2'b00, Pterm};
            default:     src0 = 16'h0000;
        endcase
    end

    assign scaled   = ctrl.mult4 ? {src0[13:0], 2'b00} :
                      ctrl.mult2 ? {src0[14:0], 1'b0}  : src0;
    assign pre_src0 = ctrl.sub ? ~scaled : scaled;
    assign sum      = src1 + pre_src0 + {15'd0, ctrl.sub};

    always_comb begin
        sat_sum = sum;
        if (ctrl.saturate) begin
            if (sum[15] && !(&sum[14:11]))
                sat_sum = SUM_NEG_SAT;
            else if (!sum[15] && (|sum[14:11]))
                sat_sum = SUM_POS_SAT;
        end
    end

    // Sign-extend to full product width so an unsigned multiply yields the signed result.
    assign op1     = {{15{src1[14]}}, src1[14:0]};
    assign op0     = {{15{src0[14]}}, src0[14:0]};
    assign product = op1 * op0;
    assign unused_prod_lsb = ^product[11:0];

    always_comb begin
        mult_sat = product[27:12];
        if (product[29] && !(&product[28:26]))
            mult_sat = MUL_NEG_SAT;
        else if (!product[29] && (|product[28:26]))
            mult_sat = MUL_POS_SAT;
    end

    assign dst = ctrl.multiply ? mult_sat : sat_sum;

endmodule

// File: rtl/pi_seq.sv
// PI line-follower sequencer: reads six IR channels, forms the steering error,
// updates integrator and P/I terms on the shared ALU, emits right/left drive.
//
// state | meaning
// IDLE  | wait for go; clear accumulator and channel index
// CONV  | strt_cnv pulse for channel tbl[idx]
// WAIT  | wait for cnv_cmplt, capture a2d_res
// ACC   | weighted accumulate of the reading (last one saturates into err)
// INTG  | integrator += err>>>4, saturated
// ICMP  | icomp = Iterm * intgrl
// PCMP  | pcomp = err * Pterm
// RSUB  | accum = Fwd - pcomp
// RHT   | rht = accum + icomp, saturated
// LADD  | accum = Fwd + pcomp
// LFT   | lft = accum - icomp, saturated; pulse done
module pi_seq
    import pi_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [11:0] Iterm,
    input  logic [13:0] Pterm,
    input  logic [11:0] Fwd,
    input  logic [11:0] a2d_res,
    input  logic        cnv_cmplt,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] rht,
    output logic [11:0] lft,
    output logic        done
);

    state_t      state;
    logic [15:0] accum, pcomp;
    logic [11:0] err, intgrl, icomp, a2d_q;
    logic [2:0]  idx;
    alu_ctrl_t   ctrl;
    logic [15:0] dst;

    alu u_alu (
        .accum   (accum),
        .pcomp   (pcomp),
        .err     (err),
        .intgrl  (intgrl),
        .icomp   (icomp),
        .a2d_res (a2d_q),
        .Iterm   (Iterm),
        .Fwd     (Fwd),
        .Pterm   (Pterm),
        .ctrl    (ctrl),
        .dst     (dst)
    );

    always_comb begin
        ctrl = '0;
        case (state)
            ACC: begin
                ctrl.src1sel = SRC1_ACCUM;
                ctrl.src0sel = SRC0_A2D;
                case (idx)
                    3'd1: ctrl.sub = 1'b1;
                    3'd2: ctrl.mult2 = 1'b1;
                    3'd3: begin ctrl.mult2 = 1'b1; ctrl.sub = 1'b1; end
                    3'd4: ctrl.mult4 = 1'b1;
                    3'd5: begin
                        ctrl.mult4    = 1'b1;
                        ctrl.sub      = 1'b1;
                        ctrl.saturate = 1'b1;
                    end
                    default: ;
                endcase
            end
            INTG: begin
                ctrl.src1sel  = SRC1_ERROR2;
                ctrl.src0sel  = SRC0_INTGRL;
                ctrl.saturate = 1'b1;
            end
            ICMP: begin
                ctrl.src1sel  = SRC1_ITERM;
                ctrl.src0sel  = SRC0_INTGRL;
                ctrl.multiply = 1'b1;
            end
            PCMP: begin
                ctrl.src1sel  = SRC1_ERROR1;
                ctrl.src0sel  = SRC0_PTERM;
                ctrl.multiply = 1'b1;
            end
            RSUB: begin
                ctrl.src1sel = SRC1_FWD;
                ctrl.src0sel = SRC0_PCOMP;
                ctrl.sub     = 1'b1;
            end
            RHT: begin
                ctrl.src1sel  = SRC1_ACCUM;
                ctrl.src0sel  = SRC0_ICOMP;
                ctrl.saturate = 1'b1;
            end
            LADD: begin
                ctrl.src1sel = SRC1_FWD;
                ctrl.src0sel = SRC0_PCOMP;
            end
            LFT: begin
                ctrl.src1sel  = SRC1_ACCUM;
                ctrl.src0sel  = SRC0_ICOMP;
                ctrl.sub      = 1'b1;
                ctrl.saturate = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            accum    <= '0;
            pcomp    <= '0;
            err      <= '0;
            intgrl   <= '0;
            icomp    <= '0;
            a2d_q    <= '0;
            idx      <= '0;
            strt_cnv <= 1'b0;
            chnnl    <= '0;
            rht      <= '0;
            lft      <= '0;
            done     <= 1'b0;
        end else begin
            strt_cnv <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    accum    <= '0;
                    idx      <= '0;
                    strt_cnv <= 1'b1;
                    chnnl    <= chnnl_of(3'd0);
                    state    <= CONV;
                end
                CONV: state <= WAIT;
                WAIT: if (cnv_cmplt) begin
                    a2d_q <= a2d_res;
                    state <= ACC;
                end
                ACC: begin
                    accum <= dst;
                    if (idx == LAST_IDX) begin
                        err   <= dst[11:0];
                        state <= INTG;
                    end else begin
                        idx      <= idx + 3'd1;
                        strt_cnv <= 1'b1;
                        chnnl    <= chnnl_of(idx + 3'd1);
                        state    <= CONV;
                    end
                end
                INTG: begin intgrl <= dst[11:0]; state <= ICMP; end
                ICMP: begin icomp  <= dst[11:0]; state <= PCMP; end
                PCMP: begin pcomp  <= dst;       state <= RSUB; end
                RSUB: begin accum  <= dst;       state <= RHT;  end
                RHT:  begin rht    <= dst[11:0]; state <= LADD; end
                LADD: begin accum  <= dst;       state <= LFT;  end
                LFT: begin
                    lft   <= dst[11:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pi_seq.sv
// Self-checking bench for pi_seq: directed and randomized control cycles checked
// against an integer-arithmetic model of the PI steering computation.
module tb_pi_seq;

    logic        clk = 1'b0;
    logic        rst, go, cnv_cmplt;
    logic [11:0] Iterm, Fwd, a2d_res;
    logic [13:0] Pterm;
    logic        strt_cnv, done;
    logic [2:0]  chnnl;
    logic [11:0] rht, lft;

    always #5 clk = ~clk;

    pi_seq dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .Iterm     (Iterm),
        .Pterm     (Pterm),
        .Fwd       (Fwd),
        .a2d_res   (a2d_res),
        .cnv_cmplt (cnv_cmplt),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .rht       (rht),
        .lft       (lft),
        .done      (done)
    );

    int          tests = 0;
    int          fails = 0;
    logic [11:0] rd [6];
    int          chn_tbl [6] = '{1, 0, 4, 2, 3, 7};
    int          j_len;
    bit          noise;
    int          m_intgrl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input longint v, input longint lo, input longint hi);
        if (v < lo) return int'(lo);
        if (v > hi) return int'(hi);
        return int'(v);
    endfunction

    // Fixed-point gain: (a*b)/4096 rounded toward -inf, limited to 15-bit signed.
    function automatic int mulsat(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        p = p >>> 12;
        return clamp(p, -16384, 16383);
    endfunction

    task automatic model(output logic [11:0] r, output logic [11:0] l);
        int s, e, ic, pc;
        s = int'(rd[0]) - int'(rd[1]) + 2 * int'(rd[2]) - 2 * int'(rd[3])
            + 4 * int'(rd[4]) - 4 * int'(rd[5]);
        e = clamp(s, -2048, 2047);
        m_intgrl = clamp(m_intgrl + (e >>> 4), -2048, 2047);
        ic = mulsat(int'(Iterm), m_intgrl);
        pc = mulsat(e, int'(Pterm));
        r = 12'(clamp(int'(Fwd) - pc + ic, -2048, 2047));
        l = 12'(clamp(int'(Fwd) + pc - ic, -2048, 2047));
    endtask

    // Enter just after a rising edge with the DUT idle; returns in the done cycle.
    task automatic run_cycle(input string tag);
        int          cyc = 0;
        int          k = 0;
        int          pend = -1;
        int          done_cyc = -1;
        logic [11:0] er, el;
        model(er, el);
        go = 1'b1;
        while (done_cyc < 0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            go = 1'b0;
            cnv_cmplt = 1'b0;
            if (strt_cnv) begin
                if (k < 6) check({tag, ":chnnl"}, 32'(chnnl), 32'(chn_tbl[k]));
                k++;
                pend = cyc + j_len;
                if (noise) begin cnv_cmplt = 1'b1; a2d_res = 12'($urandom); end
            end
            if (cyc == pend && k > 0) begin
                cnv_cmplt = 1'b1;
                a2d_res = rd[k - 1];
            end else if (noise && cyc == pend + 1) begin
                cnv_cmplt = 1'b1;
                a2d_res = 12'($urandom);
            end
            if (noise && !done && $urandom_range(0, 2) == 0) go = 1'b1;
            if (done) done_cyc = cyc;
        end
        check({tag, ":strt_count"}, 32'(k), 32'd6);
        check({tag, ":done_cycle"}, 32'(done_cyc), 32'(6 * (2 + j_len) + 8));
        check({tag, ":rht"}, 32'(rht), 32'(er));
        check({tag, ":lft"}, 32'(lft), 32'(el));
    endtask

    task automatic set_reads(input logic [11:0] v);
        for (int i = 0; i < 6; i++) rd[i] = v;
    endtask

    initial begin
        int k, pend, cyc, seen;
        rst = 1'b1; go = 1'b0; cnv_cmplt = 1'b0; a2d_res = '0;
        Iterm = '0; Pterm = '0; Fwd = '0;
        j_len = 1; noise = 1'b0; m_intgrl = 0;
        @(posedge clk); #1;
        check("reset:strt_cnv", 32'(strt_cnv), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:rht", 32'(rht), 32'd0);
        check("reset:lft", 32'(lft), 32'd0);
        check("reset:chnnl", 32'(chnnl), 32'd0);
        check("reset:intgrl", 32'(dut.intgrl), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Balanced sensors
        Fwd = 12'h300; Pterm = 14'h3680; Iterm = 12'h500;
        set_reads(12'h100);
        run_cycle("balanced");
        check("balanced:err", 32'(dut.err), 32'd0);
        check("balanced:rht_abs", 32'(rht), 32'h300);
        check("balanced:lft_abs", 32'(lft), 32'h300);

        // Right sensor hit
        set_reads(12'h000); rd[0] = 12'h7FF;
        run_cycle("right_hit");
        check("right_hit:err", 32'(dut.err), 32'h7FF);
        check("right_hit:intgrl", 32'(dut.intgrl), 32'h07F);
        check("right_hit:icomp", 32'(dut.icomp), 32'h027);
        check("right_hit:pcomp", 32'(dut.pcomp), 32'h1B3C);
        check("right_hit:rht_abs", 32'(rht), 32'h800);
        check("right_hit:lft_abs", 32'(lft), 32'h7FF);

        // Outer-left sensor at full scale saturates the error
        set_reads(12'h000); rd[5] = 12'hFFF;
        run_cycle("left_hit");
        check("left_hit:err", 32'(dut.err), 32'h800);

        // Integrator saturation over back-to-back cycles from a cleared integrator
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_intgrl = 0;
        set_reads(12'h000); rd[0] = 12'h7FF;
        for (int i = 1; i <= 19; i++) begin
            run_cycle("integ");
            if (i == 16) check("integ:intgrl_16", 32'(dut.intgrl), 32'h7F0);
            if (i >= 17) check("integ:intgrl_sat", 32'(dut.intgrl), 32'h7FF);
        end

        // Slow A2D with stray go and cnv_cmplt pulses
        j_len = 10; noise = 1'b1;
        for (int i = 0; i < 6; i++) rd[i] = 12'($urandom);
        run_cycle("slow");
        noise = 1'b0;

        // Randomized gains, readings and A2D latency
        for (int n = 0; n < 8; n++) begin
            Fwd = 12'($urandom); Pterm = 14'($urandom); Iterm = 12'($urandom);
            for (int i = 0; i < 6; i++) rd[i] = 12'($urandom);
            j_len = $urandom_range(1, 4);
            run_cycle("random");
        end

        // Put nonzero drive on the outputs, then reset during WAIT of channel 3
        Fwd = 12'h300; Pterm = 14'h3680; Iterm = 12'h500; j_len = 1;
        set_reads(12'h000); rd[0] = 12'h7FF;
        run_cycle("pre_rst");
        j_len = 10;
        go = 1'b1; k = 0; pend = -1; cyc = 0;
        while (k < 4 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            go = 1'b0; cnv_cmplt = 1'b0;
            if (strt_cnv) begin k++; pend = cyc + j_len; end
            if (cyc == pend && k > 0) begin cnv_cmplt = 1'b1; a2d_res = rd[k - 1]; end
        end
        check("rst_mid:reached_ch3", 32'(k), 32'd4);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_intgrl = 0;
        check("rst_mid:state", 32'(dut.state), 32'(pi_seq_pkg::IDLE));
        check("rst_mid:strt_cnv", 32'(strt_cnv), 32'd0);
        check("rst_mid:intgrl", 32'(dut.intgrl), 32'd0);
        check("rst_mid:rht", 32'(rht), 32'd0);
        check("rst_mid:lft", 32'(lft), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (strt_cnv || done) seen++;
        end
        check("rst_mid:quiet", 32'(seen), 32'd0);
        j_len = 1;
        run_cycle("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
